// File: rtl/slv_read_responder.sv
// AXI4 read-only slave endpoint: queues AR requests and returns each burst from
// an internal word memory, with a backdoor write port for preloading contents.
module slv_read_responder #(
    parameter int OUTSTANDING_AMT   = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MEM_DEPTH         = 256
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]     s_ARID_i,
    input  logic [ADDR_WIDTH-1:0]         s_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]      s_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]   s_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]  s_ARSIZE_i,
    input  logic                          s_ARVALID_i,
    output logic                          s_ARREADY_o,
    output logic [TRANS_MST_ID_W-1:0]     s_RID_o,
    output logic [DATA_WIDTH-1:0]         s_RDATA_o,
    output logic [1:0]                    s_RRESP_o,
    output logic                          s_RLAST_o,
    output logic                          s_RVALID_o,
    input  logic                          s_RREADY_i,
    input  logic                          mem_wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  mem_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         mem_wr_data_i
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int MEM_AW   = $clog2(MEM_DEPTH);
    localparam int PTR_W    = $clog2(OUTSTANDING_AMT);
    localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;

    localparam logic [TRANS_BURST_W-1:0] BURST_INCR = TRANS_BURST_W'(1);

    typedef enum logic { IDLE, BURST } state_t;

    // ---------------- AR queue ----------------
    logic [TRANS_MST_ID_W-1:0]    q_id    [OUTSTANDING_AMT];
    logic [ADDR_WIDTH-1:0]        q_addr  [OUTSTANDING_AMT];
    logic [TRANS_BURST_W-1:0]     q_burst [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  q_len   [OUTSTANDING_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] q_size  [OUTSTANDING_AMT];

    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           empty, full, push, pop;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign s_ARREADY_o = !full && ARESETn_i;
    assign push        = s_ARVALID_i && s_ARREADY_o;

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            q_id[wr_ptr[PTR_W-1:0]]    <= s_ARID_i;
            q_addr[wr_ptr[PTR_W-1:0]]  <= s_ARADDR_i;
            q_burst[wr_ptr[PTR_W-1:0]] <= s_ARBURST_i;
            q_len[wr_ptr[PTR_W-1:0]]   <= s_ARLEN_i;
            q_size[wr_ptr[PTR_W-1:0]]  <= s_ARSIZE_i;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- memory ----------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge ACLK_i) begin
        if (mem_wr_en_i) mem[mem_wr_addr_i] <= mem_wr_data_i;
    end

    // ---------------- burst engine ----------------
    state_t                       state, state_next;
    logic [TRANS_MST_ID_W-1:0]    cur_id;
    logic [ADDR_WIDTH-1:0]        cur_addr;
    logic [TRANS_BURST_W-1:0]     cur_burst;
    logic [TRANS_DATA_SIZE_W-1:0] cur_size;
    logic [TRANS_DATA_LEN_W-1:0]  beats_left;
    logic                         load, advance, finish;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (s_RVALID_o && s_RREADY_i) begin
                    if (!s_RLAST_o) begin
                        advance = 1'b1;
                    end else if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next beat comes either from the FIFO head (new burst) or from the
    // stepped current burst.
    logic [TRANS_MST_ID_W-1:0]    b_id;
    logic [ADDR_WIDTH-1:0]        b_addr;
    logic [TRANS_BURST_W-1:0]     b_burst;
    logic [TRANS_DATA_SIZE_W-1:0] b_size;
    logic [TRANS_DATA_LEN_W-1:0]  b_left;

    always_comb begin
        b_id    = cur_id;
        b_addr  = cur_addr;
        b_burst = cur_burst;
        b_size  = cur_size;
        b_left  = beats_left - 1'b1;
        if (load) begin
            b_id    = q_id[rd_ptr[PTR_W-1:0]];
            b_addr  = q_addr[rd_ptr[PTR_W-1:0]];
            b_burst = q_burst[rd_ptr[PTR_W-1:0]];
            b_size  = q_size[rd_ptr[PTR_W-1:0]];
            b_left  = q_len[rd_ptr[PTR_W-1:0]];
        end else if (cur_burst == BURST_INCR) begin
            b_addr = cur_addr + (ADDR_WIDTH'(1) << cur_size);
        end
    end

    logic [WORD_W-1:0]     b_word;
    logic                  b_slverr, b_decerr;
    logic [1:0]            b_resp;
    logic [DATA_WIDTH-1:0] b_data;

    assign b_word   = b_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign b_slverr = (b_burst[TRANS_BURST_W-1:1] != '0) || (int'(b_size) > ADDR_LSB);
    assign b_decerr = ((b_word >> MEM_AW) != '0);

    always_comb begin
        b_resp = 2'b00;
        b_data = mem[b_word[MEM_AW-1:0]];
        if (b_slverr) begin
            b_resp = 2'b10;
            b_data = '0;
        end else if (b_decerr) begin
            b_resp = 2'b11;
            b_data = '0;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state      <= IDLE;
            cur_id     <= '0;
            cur_addr   <= '0;
            cur_burst  <= '0;
            cur_size   <= '0;
            beats_left <= '0;
            s_RVALID_o <= 1'b0;
            s_RID_o    <= '0;
            s_RDATA_o  <= '0;
            s_RRESP_o  <= '0;
            s_RLAST_o  <= 1'b0;
        end else begin
            state <= state_next;
            if (load || advance) begin
                cur_id     <= b_id;
                cur_addr   <= b_addr;
                cur_burst  <= b_burst;
                cur_size   <= b_size;
                beats_left <= b_left;
                s_RVALID_o <= 1'b1;
                s_RID_o    <= b_id;
                s_RDATA_o  <= b_data;
                s_RRESP_o  <= b_resp;
                s_RLAST_o  <= (b_left == '0);
            end else if (finish) begin
                s_RVALID_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slv_read_responder.sv
// Directed bench for slv_read_responder: preload, single/INCR/FIXED bursts,
// full-queue drain, error responses and asynchronous reset mid-burst.
module tb_slv_read_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ar_id;
    logic [31:0] ar_addr;
    logic [1:0]  ar_burst;
    logic [2:0]  ar_len;
    logic [2:0]  ar_size;
    logic        ar_valid;
    logic        ar_ready;
    logic [4:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slv_read_responder dut (
        .ACLK_i        (clk),
        .ARESETn_i     (rst_n),
        .s_ARID_i      (ar_id),
        .s_ARADDR_i    (ar_addr),
        .s_ARBURST_i   (ar_burst),
        .s_ARLEN_i     (ar_len),
        .s_ARSIZE_i    (ar_size),
        .s_ARVALID_i   (ar_valid),
        .s_ARREADY_o   (ar_ready),
        .s_RID_o       (r_id),
        .s_RDATA_o     (r_data),
        .s_RRESP_o     (r_resp),
        .s_RLAST_o     (r_last),
        .s_RVALID_o    (r_valid),
        .s_RREADY_i    (r_ready),
        .mem_wr_en_i   (wr_en),
        .mem_wr_addr_i (wr_addr),
        .mem_wr_data_i (wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [4:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        chk({tag, ".rvalid"}, 64'(r_valid), 64'(1'b1));
        chk({tag, ".rid"},    64'(r_id),    64'(id));
        chk({tag, ".rdata"},  64'(r_data),  64'(data));
        chk({tag, ".rresp"},  64'(r_resp),  64'(resp));
        chk({tag, ".rlast"},  64'(r_last),  64'(last));
    endtask

    task automatic send_ar(input logic [4:0] id, input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] len, input logic [2:0] size);
        int n = 0;
        ar_id = id; ar_addr = addr; ar_burst = burst; ar_len = len; ar_size = size;
        ar_valid = 1'b1;
        while (!ar_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ar_accept", 64'(ar_ready), 64'(1'b1));
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!r_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".wait_rvalid"}, 64'(r_valid), 64'(1'b1));
    endtask

    logic [4:0]  exp_id   [12];
    logic [31:0] exp_data [12];

    initial begin
        rst_n = 1'b0; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_burst = 2'd1;
        ar_len = '0; ar_size = 3'd2; r_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // reset values
        repeat (3) tick();
        chk("rst.arready", 64'(ar_ready), 64'(1'b0));
        chk("rst.rvalid",  64'(r_valid),  64'(1'b0));
        chk("rst.rlast",   64'(r_last),   64'(1'b0));
        chk("rst.rid",     64'(r_id),     64'(0));
        chk("rst.rdata",   64'(r_data),   64'(0));
        chk("rst.rresp",   64'(r_resp),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("release.arready", 64'(ar_ready), 64'(1'b1));

        // preload mem[i] = 0x100 + i
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_en = 1'b0;

        // single beat, latency handshake + 1
        r_ready = 1'b1;
        send_ar(5'd3, 32'h0, 2'd1, 3'd0, 3'd2);
        chk("single.latency_rvalid", 64'(r_valid), 64'(1'b0));
        tick();
        chk_beat("single", 5'd3, 32'h100, 2'b00, 1'b1);
        tick();
        chk("single.done_rvalid", 64'(r_valid), 64'(1'b0));

        // INCR burst with back-pressure 1,0,1,0,...
        send_ar(5'd5, 32'h8, 2'd1, 3'd3, 3'd2);
        wait_valid("incr");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                r_ready = 1'b0;
                chk_beat("incr.pre_stall", 5'd5, 32'h102 + 32'(i), 2'b00, i == 3);
                tick();
                chk_beat("incr.held", 5'd5, 32'h102 + 32'(i), 2'b00, i == 3);
            end else begin
                chk_beat("incr.first", 5'd5, 32'h102, 2'b00, 1'b0);
            end
            r_ready = 1'b1;
            tick();
        end
        chk("incr.done_rvalid", 64'(r_valid), 64'(1'b0));

        // FIXED burst, one beat per cycle
        send_ar(5'd7, 32'h10, 2'd0, 3'd2, 3'd2);
        wait_valid("fixed");
        for (int i = 0; i < 3; i++) begin
            chk_beat("fixed", 5'd7, 32'h104, 2'b00, i == 2);
            tick();
        end
        chk("fixed.done_rvalid", 64'(r_valid), 64'(1'b0));

        // full queue: five handshakes, sixth held off
        r_ready = 1'b0;
        ar_burst = 2'd1; ar_len = 3'd1; ar_size = 3'd2; ar_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ar_id = 5'(k); ar_addr = 32'(k * 4);
            chk("full.arready_open", 64'(ar_ready), 64'(1'b1));
            tick();
        end
        ar_id = 5'd5; ar_addr = 32'h14;
        chk("full.arready_closed", 64'(ar_ready), 64'(1'b0));
        tick();
        chk("full.still_closed", 64'(ar_ready), 64'(1'b0));
        chk_beat("full.stalled_head", 5'd0, 32'h100, 2'b00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            exp_id[2*k] = 5'(k);   exp_data[2*k] = 32'h100 + 32'(k);
            exp_id[2*k+1] = 5'(k); exp_data[2*k+1] = 32'h101 + 32'(k);
        end
        r_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            logic hs;
            hs = ar_valid && ar_ready;
            chk_beat("drain", exp_id[n], exp_data[n], 2'b00, (n % 2) == 1);
            tick();
            if (hs) ar_valid = 1'b0;
        end
        chk("drain.arvalid_taken", 64'(ar_valid), 64'(1'b0));
        chk("drain.done_rvalid", 64'(r_valid), 64'(1'b0));

        // error responses
        send_ar(5'd10, 32'h400, 2'd1, 3'd1, 3'd2);
        wait_valid("decerr");
        chk_beat("decerr.b0", 5'd10, 32'h0, 2'b11, 1'b0);
        tick();
        chk_beat("decerr.b1", 5'd10, 32'h0, 2'b11, 1'b1);
        tick();
        send_ar(5'd11, 32'h0, 2'd2, 3'd0, 3'd2);
        wait_valid("slverr_burst");
        chk_beat("slverr_burst", 5'd11, 32'h0, 2'b10, 1'b1);
        tick();
        send_ar(5'd12, 32'h0, 2'd1, 3'd0, 3'd3);
        wait_valid("slverr_size");
        chk_beat("slverr_size", 5'd12, 32'h0, 2'b10, 1'b1);
        tick();
        chk("err.done_rvalid", 64'(r_valid), 64'(1'b0));

        // reset during second beat with two requests queued
        r_ready = 1'b0;
        send_ar(5'd1, 32'h0, 2'd1, 3'd3, 3'd2);
        send_ar(5'd2, 32'h20, 2'd1, 3'd0, 3'd2);
        send_ar(5'd4, 32'h24, 2'd1, 3'd0, 3'd2);
        chk_beat("rstmid.b0", 5'd1, 32'h100, 2'b00, 1'b0);
        r_ready = 1'b1;
        tick();
        chk_beat("rstmid.b1", 5'd1, 32'h101, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid.rvalid_async", 64'(r_valid),  64'(1'b0));
        chk("rstmid.arready",      64'(ar_ready), 64'(1'b0));
        chk("rstmid.rdata",        64'(r_data),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstmid.release_arready", 64'(ar_ready), 64'(1'b1));
        for (int i = 0; i < 4; i++) begin
            chk("rstmid.no_stale", 64'(r_valid), 64'(1'b0));
            tick();
        end
        send_ar(5'd9, 32'h3C, 2'd1, 3'd0, 3'd2);
        wait_valid("post_rst");
        chk_beat("post_rst", 5'd9, 32'h10F, 2'b00, 1'b1);
        tick();
        chk("post_rst.done_rvalid", 64'(r_valid), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slv_read_responder.md
# slv_read_responder

AXI4 read-side responder that terminates one slave port of the interconnect. It accepts read-address requests, queues up to `OUTSTANDING_AMT` of them, and returns each burst from an internal word memory with the request's ID, a response code and `RLAST`. It serves as the slave endpoint for interconnect read-path benches and as a simple on-chip read-only memory. A backdoor write port preloads its contents.

## Interface
- `OUTSTANDING_AMT`, 4: AR queue depth; power of two, ≥2.
- `DATA_WIDTH`, 32: R data width in bits; 32 or 64.
- `ADDR_WIDTH`, 32: AR address width.
- `TRANS_MST_ID_W`, 5: ARID/RID width.
- `TRANS_BURST_W`, 2: ARBURST width.
- `TRANS_DATA_LEN_W`, 3: ARLEN width; a burst has ARLEN+1 beats.
- `TRANS_DATA_SIZE_W`, 3: ARSIZE width.
- `MEM_DEPTH`, 256: memory depth in words; power of two.
- `ACLK_i` in 1: clock; all state changes on the rising edge.
- `ARESETn_i` in 1: asynchronous, active-low reset.
- `s_ARID_i` in TRANS_MST_ID_W: request ID.
- `s_ARADDR_i` in ADDR_WIDTH: byte address.
- `s_ARBURST_i` in TRANS_BURST_W: 0 FIXED, 1 INCR, 2/3 unsupported.
- `s_ARLEN_i` in TRANS_DATA_LEN_W: beats minus one.
- `s_ARSIZE_i` in TRANS_DATA_SIZE_W: log2 bytes per beat.
- `s_ARVALID_i` in 1 / `s_ARREADY_o` out 1: AR handshake.
- `s_RID_o` out TRANS_MST_ID_W, `s_RDATA_o` out DATA_WIDTH, `s_RRESP_o` out 2, `s_RLAST_o` out 1: R payload.
- `s_RVALID_o` out 1 / `s_RREADY_i` in 1: R handshake.
- `mem_wr_en_i` in 1, `mem_wr_addr_i` in $clog2(MEM_DEPTH), `mem_wr_data_i` in DATA_WIDTH: backdoor word write.

## Operation
- **AR queue.** FIFO of {ID, ADDR, BURST, LEN, SIZE}. Push on `s_ARVALID_i && s_ARREADY_o`.
  - `s_ARREADY_o` = !full && reset deasserted.
  - When full, no push is accepted, even in a cycle that also pops.
- **Burst engine FSM, state IDLE.** If the FIFO is not empty:
  - Pop the head and load the current burst: id, addr, burst, size, and beats_left = LEN.
  - Register the first beat onto the R outputs with `s_RVALID_o` = 1.
  - Go to BURST.
- **Burst engine FSM, state BURST.** On each `s_RVALID_o && s_RREADY_i`:
  - If `s_RLAST_o` = 0: advance the address and register the next beat.
  - If `s_RLAST_o` = 1 and the FIFO is not empty: pop and register the first beat of the next burst in the same edge (no bubble).
  - If `s_RLAST_o` = 1 and the FIFO is empty: `s_RVALID_o` = 0 and go to IDLE.
- **Address step.**
  - INCR: addr += 1<<size, modulo 2^ADDR_WIDTH.
  - FIXED: addr is unchanged.
  - beats_left decrements per beat; `s_RLAST_o` = (beats_left == 0).
- **Data.**
  - ADDR_LSB = $clog2(DATA_WIDTH/8); word = addr >> ADDR_LSB.
  - The full aligned word `mem[word]` is returned; no lane steering for narrow sizes.
- **Response code, evaluated per beat in priority order:**
  - BURST ≥ 2 or size > ADDR_LSB → RRESP 2'b10 (SLVERR), data 0, for the whole burst.
  - Else word ≥ MEM_DEPTH → RRESP 2'b11 (DECERR), data 0.
  - Else RRESP 2'b00.
  - The beat count, ID and RLAST are always honoured, including on error beats.
- **Backdoor write.** `mem_wr_en_i` writes `mem[mem_wr_addr_i]` at the edge. A beat registered at the same edge from the same word returns the old data. The memory is not reset.

## Timing
- **Reset values.** While `ARESETn_i` is low:
  - `s_ARREADY_o` = 0, `s_RVALID_o` = 0, `s_RLAST_o` = 0.
  - `s_RID_o` = 0, `s_RDATA_o` = 0, `s_RRESP_o` = 0.
  - FIFO empty, FSM in IDLE.
- **Reset release.** `s_ARREADY_o` = 1 in the first cycle after release.
- **Reset mid-operation.** Asynchronous: the current burst and all queued requests are discarded and `s_RVALID_o` drops immediately.
- **Latency.** An AR handshake sampled at edge t with the engine idle and the FIFO empty → first beat valid after edge t+1.
- **Throughput.** One beat per cycle while `s_RREADY_i` = 1, including across burst boundaries.
- **Stall.** While `s_RVALID_o && !s_RREADY_i`, all R outputs hold stable.
- **Capacity.** Up to OUTSTANDING_AMT+1 requests accepted: one in the engine plus OUTSTANDING_AMT in the FIFO.
- **Ordering.** Bursts are returned strictly in acceptance order, regardless of ID.

## Test plan
- **Single beat.** Preload mem[i] = 0x100+i for i = 0..15. AR id 3, addr 0x0, len 0, INCR, size 2 → one beat after handshake+1: RID 3, RDATA 0x100, RRESP 0, RLAST 1.
- **INCR burst with back-pressure.** AR id 5, addr 0x8, len 3, INCR, size 2; RREADY pattern 1,0,1,0… → RDATA 0x102, 0x103, 0x104, 0x105; RLAST only on the fourth beat; outputs held stable during each stall cycle.
- **FIXED burst.** AR id 7, addr 0x10, len 2, FIXED → RDATA 0x104 three times; RLAST on the third beat.
- **Full queue then drain.** RREADY=0; issue six ARs with ids 0..5 → five handshakes, then `s_ARREADY_o` = 0 with the sixth pending. Raise RREADY → bursts return in id order 0..5 with no idle cycle between an RLAST beat and the next first beat.
- **Error responses.**
  - AR addr 0x400, len 1 → two beats, RRESP 2'b11, RDATA 0, RLAST on the second.
  - AR burst 2'b10, len 0 → one beat, RRESP 2'b10.
  - AR size 3 with DATA_WIDTH 32 → RRESP 2'b10.
- **Reset mid-burst.** During the second beat of a len-3 burst with two ARs queued, pulse ARESETn_i low → RVALID 0 immediately. After release, ARREADY is 1, no stale beats appear, and a new AR returns correct data.
